// File: rtl/exec_ctrl.sv
// Run/halt/step/breakpoint sequencer: run_en is combinational from state and halt_req/bp_match; go press reaches run_en 3+DEB_N cycles after the pin.
// No backpressure: halt_req/bp_match drop run_en in the same cycle and halted follows on the next edge.
module exec_ctrl #(
    parameter int DEB_N = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             step_mode,
    input  logic             halt_req,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             run_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] halt_cnt
);

    localparam int DW = $clog2(DEB_N + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_HALT  = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic            skip_q, skip_d;
    logic            bp_hit_q, bp_hit_d;
    logic            go_s1_q, go_s1_d;
    logic            go_s2_q, go_s2_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic            deb_lvl_q, deb_lvl_d;
    logic            go_pulse_q, go_pulse_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] halt_cnt_q, halt_cnt_d;
    logic            bp_match;

    assign bp_match = bp_en & (pc == bp_addr);

    // The pulse is registered alongside the level flip so it lasts exactly one cycle per press.
    always_comb begin
        go_s1_d    = go;
        go_s2_d    = go_s1_q;
        deb_cnt_d  = '0;
        deb_lvl_d  = deb_lvl_q;
        go_pulse_d = 1'b0;
        if (go_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DW'(DEB_N - 1)) begin
                deb_lvl_d  = ~deb_lvl_q;
                go_pulse_d = ~deb_lvl_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        bp_hit_d = bp_hit_q;
        run_en   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                run_en = skip_q | ~(halt_req | bp_match);
                // skip lets the instruction we stopped on execute once after resuming
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (bp_match) begin
                    state_d  = S_BREAK;
                    bp_hit_d = 1'b1;
                end
            end
            S_HALT, S_BREAK: begin
                if (go_pulse_q) begin
                    if (step_mode) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_RUN;
                        skip_d  = 1'b1;
                    end
                end
            end
            S_STEP: begin
                run_en  = 1'b1;
                state_d = S_HALT;
            end
        endcase
    end

    assign halted = (state_q == S_HALT) || (state_q == S_BREAK);

    always_comb begin
        instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, run_en};
        halt_cnt_d  = halt_cnt_q + {{(CNT_W-1){1'b0}}, halted};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
            go_s1_q     <= 1'b0;
            go_s2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            deb_lvl_q   <= 1'b0;
            go_pulse_q  <= 1'b0;
            instr_cnt_q <= '0;
            halt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            bp_hit_q    <= bp_hit_d;
            go_s1_q     <= go_s1_d;
            go_s2_q     <= go_s2_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_lvl_q   <= deb_lvl_d;
            go_pulse_q  <= go_pulse_d;
            instr_cnt_q <= instr_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
        end
    end

    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = instr_cnt_q;
    assign halt_cnt  = halt_cnt_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: free run, syscall pause, breakpoint, single step, debounce, async reset.
module tb_exec_ctrl;
    localparam int DEB_N = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             go = 1'b0;
    logic             step_mode = 1'b0;
    logic             halt_req = 1'b0;
    logic             bp_en = 1'b0;
    logic [31:0]      bp_addr = '0;
    logic [31:0]      pc = '0;
    logic             run_en;
    logic [1:0]       state;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] halt_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int ones, first_on, step_seen;
    bit pc_adv = 1'b0;

    exec_ctrl #(.DEB_N(DEB_N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .go(go), .step_mode(step_mode),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .run_en(run_en), .state(state), .halted(halted), .bp_hit(bp_hit),
        .instr_cnt(instr_cnt), .halt_cnt(halt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; go = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = '0; pc = '0; pc_adv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // n cycles from a negedge; go held (or toggled) for the first 'hold' cycles
    task automatic run_go(input int n, input int hold, input bit toggle);
        logic re;
        ones = 0; first_on = -1; step_seen = 0;
        for (int i = 0; i < n; i++) begin
            go = (i < hold) ? (toggle ? i[0] : 1'b1) : 1'b0;
            #1;
            re = run_en;
            if (re) begin
                ones++;
                if (first_on < 0) first_on = i;
            end
            if (state == 2'b10) step_seen++;
            @(negedge clk);
            if (pc_adv && re) pc = pc + 32'd4;
        end
        go = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset values while rst is held low
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_state", state, 2'b00);
        chk("rst_instr", instr_cnt, 0);
        chk("rst_halt", halt_cnt, 0);
        chk("rst_bp_hit", bp_hit, 0);
        chk("rst_halted", halted, 0);

        // free run, then wrap of the narrowed counter
        do_reset();
        for (int i = 0; i < 260; i++) begin
            #1;
            if (i < 10) chk("free_run_en", run_en, 1);
            @(negedge clk);
            if (i == 9) begin
                chk("free_instr10", instr_cnt, 10);
                chk("free_state", state, 2'b00);
                chk("free_halt_cnt", halt_cnt, 0);
            end
        end
        chk("instr_wrap", instr_cnt, 4);

        // syscall pause, go with halt_req still asserted
        do_reset();
        run_go(5, 0, 1'b0);
        halt_req = 1'b1;
        #1;
        chk("pause_run_en", run_en, 0);
        @(negedge clk);
        chk("pause_state", state, 2'b01);
        chk("pause_instr", instr_cnt, 5);
        chk("pause_halt_cnt0", halt_cnt, 0);
        run_go(60, DEB_N + 4, 1'b0);
        chk("pause_go_ones", ones, 1);
        chk("pause_go_lat", first_on, DEB_N + 3);
        chk("pause_state2", state, 2'b01);
        chk("pause_instr2", instr_cnt, 6);
        chk("pause_halt_cnt", halt_cnt, 58);
        halt_req = 1'b0;

        // breakpoint at 0x10
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h10; pc_adv = 1'b1;
        run_go(4, 0, 1'b0);
        chk("bp_pc", pc, 32'h10);
        #1;
        chk("bp_run_en", run_en, 0);
        @(negedge clk);
        chk("bp_state", state, 2'b11);
        chk("bp_hit", bp_hit, 1);
        chk("bp_instr", instr_cnt, 4);
        run_go(60, 20, 1'b0);
        chk("bp_resume_lat", first_on, DEB_N + 3);
        chk("bp_resume_ones", ones, 41);
        chk("bp_resume_state", state, 2'b00);
        chk("bp_hit_sticky", bp_hit, 1);
        chk("bp_resume_instr", instr_cnt, 45);
        pc_adv = 1'b0;

        // single step: three presses
        do_reset();
        halt_req = 1'b1;
        @(negedge clk);
        chk("step_halt", state, 2'b01);
        chk("step_instr0", instr_cnt, 0);
        halt_req = 1'b0; step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_go(60, 20, 1'b0);
            chk("step_ones", ones, 1);
            chk("step_seen", step_seen, 1);
            chk("step_back_halt", state, 2'b01);
        end
        chk("step_instr3", instr_cnt, 3);

        // debounce: short press and chatter
        run_go(60, DEB_N - 2, 1'b0);
        chk("deb_short_ones", ones, 0);
        chk("deb_short_state", state, 2'b01);
        run_go(100, 100, 1'b1);
        chk("deb_toggle_ones", ones, 0);
        chk("deb_toggle_state", state, 2'b01);
        chk("deb_instr", instr_cnt, 3);

        // async reset in the middle of a step
        do_reset();
        bp_en = 1'b1; bp_addr = 32'h1C; pc_adv = 1'b1; step_mode = 1'b1;
        run_go(7, 0, 1'b0);
        @(negedge clk);
        chk("mid_break", state, 2'b11);
        for (int i = 0; i < 60; i++) begin
            go = (i < 20);
            #1;
            if (state == 2'b10) break;
            @(negedge clk);
        end
        chk("mid_step", state, 2'b10);
        chk("mid_instr7", instr_cnt, 7);
        chk("mid_bp_hit", bp_hit, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_instr", instr_cnt, 0);
        chk("arst_bp_hit", bp_hit, 0);
        go = 1'b0; bp_en = 1'b0; pc_adv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_run_en", run_en, 1);
        @(negedge clk);
        chk("post_rst_instr", instr_cnt, 1);
        chk("post_rst_state", state, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
Execution sequencer for the single-cycle CPU. It generates the run enable that gates the PC register and the instruction counter. The enable stops on syscall pause requests and on PC breakpoints. Execution resumes, either free-running or one instruction at a time, on a debounced go button press. It replaces the ad-hoc run/pause/go gating at the CPU top level and exports status for the display mux.

Parameters:
DEB_N, 16, consecutive stable synchronised samples of go required to change its debounced level
CNT_W, 32, width of instr_cnt and halt_cnt

Ports:
clk  input  1  CPU clock (the divided clock that drives PC, RegFile and RAM)
rst  input  1  asynchronous, active-low reset
go  input  1  raw push button, asynchronous to clk
step_mode  input  1  1: each go press executes exactly one instruction; 0: go resumes free run
halt_req  input  1  pause request from the datapath (syscall with $v0 != 34), combinational, same cycle
bp_en  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC
pc  input  32  current PC register output
run_en  output  1  enable for the PC register and the committed-instruction counting
state  output  2  00 RUN, 01 HALT, 10 STEP, 11 BREAK
halted  output  1  1 when state is HALT or BREAK
bp_hit  output  1  sticky; set on entry to BREAK, cleared only by reset
instr_cnt  output  CNT_W  number of cycles with run_en=1
halt_cnt  output  CNT_W  number of cycles with halted=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, skip=0, bp_hit=0, instr_cnt=0, halt_cnt=0.
  - go synchroniser flops, debounce counter and debounced level are all 0.
  - Takes effect immediately, including mid-STEP or mid-debounce.
- go conditioning:
  - go passes through a 2-flop synchroniser.
  - A debounce counter increments while the synchronised value differs from the debounced level, and resets to 0 when they agree.
  - At DEB_N the debounced level flips and the counter clears.
  - go_pulse is a one-cycle pulse on the rising edge of the debounced level. There is exactly one pulse per press, regardless of hold time.
- bp_match = bp_en & (pc == bp_addr), full 32-bit compare.
- run_en (combinational from registered state, skip and the current inputs):
  - RUN: run_en = skip | ~(halt_req | bp_match).
  - STEP: run_en = 1.
  - HALT and BREAK: run_en = 0.
- Transitions, evaluated on the rising edge of clk:
  - RUN, skip=1: stay in RUN, clear skip. The resumed instruction executes even if halt_req or bp_match is 1.
  - RUN, skip=0, halt_req=1: go to HALT. halt_req takes priority over bp_match when both are 1.
  - RUN, skip=0, bp_match=1: go to BREAK and set bp_hit.
  - RUN, otherwise: stay in RUN. go_pulse is ignored in RUN.
  - HALT or BREAK with go_pulse: go to STEP if step_mode=1. Otherwise go to RUN and set skip=1.
  - HALT or BREAK without go_pulse: hold.
  - STEP: always go to HALT after one cycle, whatever step_mode, halt_req or bp_match are.
- step_mode is sampled only when leaving HALT/BREAK. Changing it in RUN has no effect until the next halt.
- Counters:
  - instr_cnt increments on every clk edge where run_en=1.
  - halt_cnt increments on every clk edge where halted=1.
  - Both wrap from 2^CNT_W-1 to 0 with no saturation.
- halted, state and bp_hit are registered outputs. run_en is the only combinational output.
- Latency:
  - halt_req=1 forces run_en=0 in the same cycle, and halted rises on the next edge.
  - From go_pulse to run_en=1 takes 1 cycle. From the go pin to go_pulse takes 2 + DEB_N cycles.

Test Plan:
- Free run: release rst, halt_req=0, bp_en=0 for 10 cycles -> run_en=1 on every cycle, instr_cnt=10, state=00, halt_cnt=0.
- Syscall pause: halt_req=1 held from cycle 5 -> run_en=0 in cycle 5, state=01 from cycle 6, instr_cnt frozen at 5. Press go for DEB_N+4 cycles -> exactly one cycle of run_en=1, then state=01 again because halt_req is still 1. instr_cnt=6.
- Breakpoint: bp_en=1, bp_addr=0x0000_0010, pc advancing 0,4,8,... -> run_en=0 when pc=0x10, state=11, bp_hit=1. go press -> the instruction at 0x10 executes and free run continues. bp_hit stays 1.
- Single step: in HALT with step_mode=1, three separate go presses -> exactly three one-cycle run_en pulses, state sequence 01→10→01 each time, instr_cnt increases by 3.
- Debounce: go high for DEB_N-2 cycles, then low -> no go_pulse, state unchanged. go toggling every cycle for 100 cycles -> no pulse.
- Reset mid-operation: drop rst while in STEP with instr_cnt=7 -> state=00, instr_cnt=0, bp_hit=0 immediately, without waiting for a clock edge. run_en=1 after release with halt_req=0.
